// File: rtl/axi_sram_pkg.sv
// Shared constants and types for the AXI read path to the on-chip SRAM.
package axi_sram_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_WORDS = 256;

    // Word i of the SRAM reads back as SRAM_INIT | i.
    localparam logic [31:0] SRAM_INIT = 32'hA5A5_0000;

    // Legacy state encodings, kept so existing probes/scripts still match.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        READ = ST_READ,
        RESP = ST_RESP
    } bridge_state_t;

endpackage

// File: rtl/axi_sram_bridge.sv
// AXI read-only slave in front of the SRAM: one outstanding read, no queueing.
module axi_sram_bridge
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = axi_sram_pkg::ADDR_W,
    parameter int unsigned DATA_W    = axi_sram_pkg::DATA_W,
    parameter int unsigned MEM_WORDS = axi_sram_pkg::MEM_WORDS
) (
    input  logic                         clk,
    input  logic                         resetn,
    // AR channel
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    // R channel
    output logic [DATA_W-1:0]            rdata,
    output logic                         rvalid,
    input  logic                         rready,
    // write channels, tied off
    input  logic                         awvalid,
    input  logic                         wvalid,
    input  logic                         bready,
    output logic                         awready,
    output logic                         wready,
    output logic                         bvalid,
    // SRAM port
    output logic                         sram_en,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    input  logic [DATA_W-1:0]            sram_rdata
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    bridge_state_t     state;
    logic [IDX_W-1:0]  idx_q;
    logic              rd_wait_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              ar_hs;
    logic              r_hs;
    logic              unused_inputs;

    assign arready = (state == IDLE) && !resetn;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid_q && rready;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;

    // The word index is latched on the AR handshake and the SRAM enable is
    // issued from that register in the first READ cycle; READ then waits one
    // more cycle for the registered SRAM output before capturing it.
    assign sram_en   = (state == READ) && rd_wait_q;
    assign sram_addr = idx_q;

    assign awready = 1'b0;
    assign wready  = 1'b0;
    assign bvalid  = 1'b0;

    assign unused_inputs = ^{awvalid, wvalid, bready,
                             araddr[ADDR_W-1:IDX_W+2], araddr[1:0]};

    // Read FSM: IDLE -> READ (enable, then capture) -> RESP (hold until rready).
    always_ff @(posedge clk) begin
        if (resetn) begin
            state     <= IDLE;
            idx_q     <= '0;
            rd_wait_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        idx_q     <= araddr[IDX_W+1:2];
                        rd_wait_q <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (rd_wait_q) begin
                        rd_wait_q <= 1'b0;
                    end else begin
                        rdata_q  <= sram_rdata;
                        rvalid_q <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (r_hs) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fake_cpu.sv
// Minimal AXI read master: one read of address 0 after reset, then quiet.
// Its channel nets are plain continuous assigns so they can be forced.
module fake_cpu
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = axi_sram_pkg::ADDR_W,
    parameter int unsigned DATA_W = axi_sram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic              awvalid,
    output logic              wvalid,
    output logic              bready,
    input  logic              awready,
    input  logic              wready,
    input  logic              bvalid
);

    logic arvalid_q;
    logic rready_q;
    logic req_done_q;
    logic axi_rd_ret;
    logic unused_inputs;

    assign araddr     = '0;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign axi_rd_ret = rvalid && rready;

    assign awvalid = 1'b0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b0;

    assign unused_inputs = ^{awready, wready, bvalid, rdata};

    // Issue a single read, then keep rready high and never request again.
    always_ff @(posedge clk) begin
        if (resetn) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            req_done_q <= 1'b0;
        end else if (!req_done_q) begin
            if (arvalid && arready) begin
                arvalid_q  <= 1'b0;
                rready_q   <= 1'b1;
                req_done_q <= 1'b1;
            end else begin
                arvalid_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram.sv
// Word-addressed synchronous-read SRAM model. Contents are the fixed init
// pattern; there is no write path, so reset never touches them.
module sram
    import axi_sram_pkg::*;
#(
    parameter int unsigned DATA_W    = axi_sram_pkg::DATA_W,
    parameter int unsigned MEM_WORDS = axi_sram_pkg::MEM_WORDS
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    output logic [DATA_W-1:0]            rdata
);

    // Registered read: data appears the cycle after en.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= DATA_W'(SRAM_INIT) | DATA_W'(addr);
        end
    end

endmodule

// File: rtl/top.sv
// Self-contained AXI read subsystem: fake CPU -> bridge -> SRAM.
module top
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = axi_sram_pkg::ADDR_W,
    parameter int unsigned DATA_W    = axi_sram_pkg::DATA_W,
    parameter int unsigned MEM_WORDS = axi_sram_pkg::MEM_WORDS
) (
    input logic clk,
    input logic resetn
);

    logic [ADDR_W-1:0]            araddr;
    logic                         arvalid;
    logic                         arready;
    logic [DATA_W-1:0]            rdata;
    logic                         rvalid;
    logic                         rready;
    logic                         awvalid;
    logic                         wvalid;
    logic                         bready;
    logic                         awready;
    logic                         wready;
    logic                         bvalid;
    logic                         sram_en;
    logic [$clog2(MEM_WORDS)-1:0] sram_addr;
    logic [DATA_W-1:0]            sram_rdata;

    fake_cpu #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) fake_cpu (
        .clk     (clk),
        .resetn  (resetn),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready),
        .awvalid (awvalid),
        .wvalid  (wvalid),
        .bready  (bready),
        .awready (awready),
        .wready  (wready),
        .bvalid  (bvalid)
    );

    axi_sram_bridge #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS)
    ) u_bridge (
        .clk       (clk),
        .resetn    (resetn),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .awvalid   (awvalid),
        .wvalid    (wvalid),
        .bready    (bready),
        .awready   (awready),
        .wready    (wready),
        .bvalid    (bvalid),
        .sram_en   (sram_en),
        .sram_addr (sram_addr),
        .sram_rdata(sram_rdata)
    );

    sram #(
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS)
    ) u_sram (
        .clk  (clk),
        .en   (sram_en),
        .addr (sram_addr),
        .rdata(sram_rdata)
    );

endmodule

// File: tb/tb_top.sv
// Directed bench for the AXI->SRAM read path, driving the CPU nets by force.
module tb_top;

    logic        clk;
    logic        resetn;
    logic [31:0] drv_araddr;
    logic        drv_arvalid;
    logic        drv_rready;
    int          n_checks;
    int          n_fail;
    int          ret_count;

    top dut (
        .clk   (clk),
        .resetn(resetn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count real R transfers (handshake at a rising edge).
    initial ret_count = 0;
    always @(posedge clk) begin
        if (dut.fake_cpu.axi_rd_ret) ret_count++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read with rready held high; checks latency, data, and rvalid clear.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int n;
        int lat;
        drv_araddr  = addr;
        drv_rready  = 1'b1;
        drv_arvalid = 1'b1;
        n = 0;
        while (!dut.fake_cpu.arready && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_arready"}, 32'(dut.fake_cpu.arready), 32'd1);
        tick();
        drv_arvalid = 1'b0;
        lat = 0;
        while (!dut.fake_cpu.axi_rd_ret && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, dut.fake_cpu.rdata, exp);
        tick();
        check({tag, "_rvalid_clr"}, 32'(dut.u_bridge.rvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int n;
        n_checks    = 0;
        n_fail      = 0;
        drv_araddr  = '0;
        drv_arvalid = 1'b0;
        drv_rready  = 1'b0;
        resetn      = 1'b1;
        force dut.fake_cpu.araddr  = drv_araddr;
        force dut.fake_cpu.arvalid = drv_arvalid;
        force dut.fake_cpu.rready  = drv_rready;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_arready", 32'(dut.fake_cpu.arready), 32'd0);
            check("rst_rvalid", 32'(dut.u_bridge.rvalid), 32'd0);
            check("rst_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
        end
        check("rst_rdata", dut.fake_cpu.rdata, 32'h0);

        // Single-cycle AR at address 0 with rready low.
        resetn = 1'b0;
        drv_arvalid = 1'b1;
        #1;
        check("hs_arready", 32'(dut.fake_cpu.arready), 32'd1);
        tick();
        drv_arvalid = 1'b0;
        check("read_arready", 32'(dut.fake_cpu.arready), 32'd0);
        check("lat1_rvalid", 32'(dut.u_bridge.rvalid), 32'd0);
        tick();
        check("lat1b_rvalid", 32'(dut.u_bridge.rvalid), 32'd0);
        tick();
        check("lat2_rvalid", 32'(dut.u_bridge.rvalid), 32'd1);
        check("lat2_rdata", dut.fake_cpu.rdata, 32'hA5A5_0000);

        // rready low for 5 cycles: response held.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rvalid", 32'(dut.u_bridge.rvalid), 32'd1);
            check("hold_rdata", dut.fake_cpu.rdata, 32'hA5A5_0000);
            check("hold_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
        end
        snap = ret_count;
        drv_rready = 1'b1;
        #1;
        check("xfer_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
        check("xfer_rdata", dut.fake_cpu.rdata, 32'hA5A5_0000);
        tick();
        drv_rready = 1'b0;
        check("post_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
        check("post_rvalid", 32'(dut.u_bridge.rvalid), 32'd0);
        check("post_idle_arready", 32'(dut.fake_cpu.arready), 32'd1);
        check("one_pulse", 32'(ret_count - snap), 32'd1);

        // Address decode: top word, wrap, ignored low and high bits.
        do_read("rd_3fc", 32'h0000_03FC, 32'hA5A5_00FF);
        do_read("rd_400", 32'h0000_0400, 32'hA5A5_0000);
        do_read("rd_013", 32'h0000_0013, 32'hA5A5_0004);
        do_read("rd_f808", 32'hFFFF_F808, 32'hA5A5_0002);

        // arvalid held high across READ/RESP: no second acceptance.
        drv_rready  = 1'b0;
        drv_araddr  = 32'h0000_0010;
        drv_arvalid = 1'b1;
        #1;
        check("busy_hs_arready", 32'(dut.fake_cpu.arready), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy_arready", 32'(dut.fake_cpu.arready), 32'd0);
        end
        check("busy_rvalid", 32'(dut.u_bridge.rvalid), 32'd1);
        check("busy_rdata", dut.fake_cpu.rdata, 32'hA5A5_0004);
        drv_araddr = 32'h0000_0020;
        drv_rready = 1'b1;
        snap = ret_count;
        #1;
        check("busy_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
        tick();
        check("busy_idle_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
        check("busy_idle_arready", 32'(dut.fake_cpu.arready), 32'd1);
        tick();
        drv_arvalid = 1'b0;
        tick();
        tick();
        check("second_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
        check("second_rdata", dut.fake_cpu.rdata, 32'hA5A5_0008);
        for (int i = 0; i < 3; i++) tick();
        check("two_beats_only", 32'(ret_count - snap), 32'd2);

        // Reset during RESP aborts the beat.
        drv_rready  = 1'b0;
        drv_araddr  = 32'h0000_03FC;
        drv_arvalid = 1'b1;
        tick();
        drv_arvalid = 1'b0;
        tick();
        tick();
        check("abort_pre_rvalid", 32'(dut.u_bridge.rvalid), 32'd1);
        snap = ret_count;
        resetn = 1'b1;
        tick();
        check("abort_rvalid", 32'(dut.u_bridge.rvalid), 32'd0);
        check("abort_arready", 32'(dut.fake_cpu.arready), 32'd0);
        check("abort_rdata", dut.fake_cpu.rdata, 32'h0);
        drv_rready = 1'b1;
        tick();
        check("abort_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort_no_beat", 32'(ret_count - snap), 32'd0);
        check("abort_idle_rvalid", 32'(dut.u_bridge.rvalid), 32'd0);

        // Unforced CPU: one read of word 0 after reset, then silence.
        resetn = 1'b1;
        release dut.fake_cpu.araddr;
        release dut.fake_cpu.arvalid;
        release dut.fake_cpu.rready;
        tick();
        tick();
        check("cpu_rst_arvalid", 32'(dut.fake_cpu.arvalid), 32'd0);
        check("cpu_rst_rready", 32'(dut.fake_cpu.rready), 32'd0);
        check("cpu_rst_araddr", dut.fake_cpu.araddr, 32'h0);
        resetn = 1'b0;
        n = 0;
        while (!dut.fake_cpu.axi_rd_ret && n < 20) begin
            tick();
            n++;
        end
        check("cpu_ret_seen", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
        check("cpu_rdata", dut.fake_cpu.rdata, 32'hA5A5_0000);
        check("cpu_arvalid_low", 32'(dut.fake_cpu.arvalid), 32'd0);
        check("cpu_rready_high", 32'(dut.fake_cpu.rready), 32'd1);
        snap = ret_count;
        for (int i = 0; i < 6; i++) tick();
        check("cpu_single_beat", 32'(ret_count - snap), 32'd1);
        check("cpu_quiet_arvalid", 32'(dut.fake_cpu.arvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The top-level ports SHALL be exactly: clk  input  1  single system clock, all logic on rising edge.
REQ-002 resetn  input  1  synchronous, active-high reset (asserted when 1), sampled on rising clk.
REQ-003 No other top-level ports SHALL exist; all traffic is internal and observable hierarchically.
REQ-004 Parameters: ADDR_W = 32 (AXI address width), DATA_W = 32 (data width), MEM_WORDS = 256 (SRAM depth).

Function
REQ-005 top SHALL instantiate fake_cpu (instance name fake_cpu), axi_sram_bridge (instance name u_bridge) and sram (instance name u_sram).
REQ-006 fake_cpu SHALL contain these nets, each forceable, at these hierarchical names: araddr[31:0], arvalid, arready, rready, rdata[31:0], axi_rd_ret.
REQ-007 AR channel: an address SHALL be accepted on a rising edge with arvalid=1 and arready=1.
REQ-008 R channel: data SHALL transfer on a rising edge with rvalid=1 and rready=1.
REQ-009 axi_rd_ret SHALL be combinational rvalid & rready, and SHALL be 1 only in the R transfer cycle.
REQ-010 Bridge states SHALL be IDLE, READ, RESP.
REQ-011 IDLE: arready=1, rvalid=0; on AR handshake, latch araddr[9:2] as word index, drive the SRAM read enable, go to READ.
REQ-012 READ: arready=0; the SRAM returns data one cycle after the read enable; latch it into rdata, set rvalid=1, go to RESP.
REQ-013 RESP: rvalid and rdata SHALL be held stable for any number of cycles until rready=1; on handshake, clear rvalid and return to IDLE.
REQ-014 Latency: the first cycle with rvalid=1 SHALL be 2 cycles after the AR handshake edge.
REQ-015 arvalid asserted outside IDLE SHALL be ignored (arready=0); no request queueing.
REQ-016 rready asserted with rvalid=0 SHALL have no effect.
REQ-017 araddr bits [1:0] and [31:10] SHALL be ignored; address wrap is modulo MEM_WORDS.
REQ-018 The SRAM SHALL be word-addressed, 32-bit, synchronous read, with word i initialised to 32'hA5A5_0000 | i (word 0 = 0xA5A50000).
REQ-019 Write channels (AW/W/B) SHALL be tied off in fake_cpu and bridge: awready=0, wready=0, bvalid=0.
REQ-020 Unforced fake_cpu SHALL, after reset, drive araddr=0 and arvalid=1 until the AR handshake, then arvalid=0, rready=1, and issue no further requests.

Reset
REQ-021 While resetn=1 at a rising edge: bridge goes to IDLE, rvalid=0, rdata=0, and arready is 0 during reset.
REQ-022 While resetn=1 at a rising edge: fake_cpu outputs arvalid=0 and rready=0, with araddr=0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no R beat delivered.
REQ-024 SRAM contents SHALL NOT be affected by reset.

Structure
REQ-025 A shared package axi_sram_pkg SHALL hold ADDR_W, DATA_W, MEM_WORDS, the bridge state enum and the SRAM init pattern constant.
REQ-026 axi_sram_bridge is the natural single sub-module; fake_cpu and sram are small leaf models in the same top.

Verification
REQ-027 Bench SHALL cover: reset for 3 cycles -> arready=0, rvalid=0, axi_rd_ret=0 throughout.
REQ-028 Bench SHALL cover: after reset, force araddr=0, arvalid=1 for 1 cycle, rready=0 -> arready=1 at handshake; rvalid=1 two cycles later; rdata=0xA5A50000 held stable.
REQ-029 Bench SHALL cover: from REQ-028 state, hold rready=0 for 5 cycles, then 1 for 1 cycle -> axi_rd_ret=1 for exactly that cycle with rdata=0xA5A50000, then IDLE.
REQ-030 Bench SHALL cover: read araddr=0x3FC with rready=1 -> rdata=0xA5A500FF; read araddr=0x400 -> rdata=0xA5A50000 (wrap).
REQ-031 Bench SHALL cover: arvalid held high during READ/RESP -> arready=0, one response only, second request accepted only after return to IDLE.
REQ-032 Bench SHALL cover: resetn=1 asserted during RESP -> rvalid=0 the next cycle, and axi_rd_ret never pulses.
